// File: rtl/ps2_host_ctrl.sv
// PS/2 host-side link controller.
// Conditions the open-drain clock/data pads, receives device frames and
// checks their parity and stop bit, and runs the host-to-device request
// sequence: clock inhibit, start bit, data/parity/stop, then the device ack.
// A single FSM owns the line, so RX and TX can never drive it together.
module ps2_host_ctrl #(
    parameter int FILT_LEN       = 4,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    input  logic       tx_req_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_err_o
);

    localparam int FW = (FILT_LEN > 1)       ? $clog2(FILT_LEN + 1)       : 1;
    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RX      = 3'd1;
    localparam logic [2:0] S_INHIBIT = 3'd2;
    localparam logic [2:0] S_TX_BITS = 3'd3;
    localparam logic [2:0] S_TX_ACK  = 3'd4;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic          clk_filt_q;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          sdata;

    // Two-flop synchronisers; reset to the idle (high) line level.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
        end
    end

    // Glitch filter: a new clock level is taken only after FILT_LEN equal
    // consecutive synced samples that differ from the current level.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_q <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // One-cycle strobe on a filtered falling edge; data is read alongside it.
    assign fall  = clk_filt_q & ~clk_filt;
    assign sdata = data_sync[1];

    // ------------------------------------------------------------------
    // Link FSM
    // ------------------------------------------------------------------
    logic [2:0]    state;
    logic [3:0]    bit_cnt;
    logic [8:0]    rx_sr;
    logic [7:0]    tx_byte;
    logic          tx_drv;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          to_active;
    logic          to_hit;

    // Frame watchdog only runs while a frame is in flight on the wire.
    assign to_active = (state == S_RX) || (state == S_TX_BITS) || (state == S_TX_ACK);
    assign to_hit    = to_active && !fall && (to_cnt == TO_LAST);

    // Watchdog: restarts on every falling edge and whenever it is idle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            to_cnt <= '0;
        end else if (fall || !to_active) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Main sequencer: RX deserialise, inhibit, TX serialise, ack check.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_byte    <= '0;
            tx_drv     <= 1'b0;
            inh_cnt    <= '0;
            rx_data_o  <= 8'h00;
            rx_valid_o <= 1'b0;
            rx_err_o   <= 1'b0;
            tx_done_o  <= 1'b0;
            tx_err_o   <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            rx_err_o   <= 1'b0;
            tx_done_o  <= 1'b0;
            tx_err_o   <= 1'b0;

            case (state)
                // A device start bit beats a pending host request; the
                // request is level-held so it is picked up afterwards.
                S_IDLE: begin
                    if (fall && !sdata) begin
                        state   <= S_RX;
                        bit_cnt <= '0;
                    end else if (tx_req_i) begin
                        tx_byte <= tx_data_i;
                        inh_cnt <= '0;
                        state   <= S_INHIBIT;
                    end
                end

                // bits 0..8 shift in data+parity LSB first; fall 10 is stop.
                S_RX: begin
                    if (fall) begin
                        if (bit_cnt == 4'd9) begin
                            if ((^rx_sr) && sdata) begin
                                rx_data_o  <= rx_sr[7:0];
                                rx_valid_o <= 1'b1;
                            end else begin
                                rx_err_o <= 1'b1;
                            end
                            state <= S_IDLE;
                        end else begin
                            rx_sr   <= {sdata, rx_sr[8:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (to_hit) begin
                        rx_err_o <= 1'b1;
                        state    <= S_IDLE;
                    end
                end

                // Clock held low; the start bit goes out on the last cycle
                // and stays driven until the device's first falling edge.
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        tx_drv  <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_TX_BITS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                // Falls 1..8 present data, 9 the odd parity, 10 releases (stop).
                S_TX_BITS: begin
                    if (fall) begin
                        if (bit_cnt < 4'd8) begin
                            tx_drv <= ~tx_byte[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            // parity bit = ~^byte; pulling low drives its inverse
                            tx_drv <= ^tx_byte;
                        end else begin
                            tx_drv <= 1'b0;
                            state  <= S_TX_ACK;
                        end
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (to_hit) begin
                        tx_drv   <= 1'b0;
                        tx_err_o <= 1'b1;
                        state    <= S_IDLE;
                    end
                end

                // Device pulls data low on the next fall to acknowledge.
                S_TX_ACK: begin
                    if (fall) begin
                        if (!sdata) begin
                            tx_done_o <= 1'b1;
                        end else begin
                            tx_err_o <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else if (to_hit) begin
                        tx_err_o <= 1'b1;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Pad drivers decode straight from state so reset or any exit releases
    // the line on the same edge.
    assign ps2_clk_oe_o  = (state == S_INHIBIT);
    assign ps2_data_oe_o = ((state == S_INHIBIT) && (inh_cnt == INH_LAST)) ||
                           ((state == S_TX_BITS) && tx_drv);
    assign tx_busy_o     = (state == S_INHIBIT) || (state == S_TX_BITS) ||
                           (state == S_TX_ACK);

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: an open-drain device model drives frames in and
// reads host frames out; expected bytes/bits come from frame arithmetic.
module tb_ps2_host_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dev_clk, dev_data;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_busy, tx_done, tx_err;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err;

    // open-drain wired-AND of device and host
    wire ps2_clk_pad  = dev_clk  & ~ps2_clk_oe;
    wire ps2_data_pad = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_ctrl #(.FILT_LEN(4), .INHIBIT_CYCLES(50), .TIMEOUT_CYCLES(2000)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ps2_clk_i(ps2_clk_pad), .ps2_data_i(ps2_data_pad),
        .ps2_clk_oe_o(ps2_clk_oe), .ps2_data_oe_o(ps2_data_oe),
        .tx_req_i(tx_req), .tx_data_i(tx_data),
        .tx_busy_o(tx_busy), .tx_done_o(tx_done), .tx_err_o(tx_err),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_err_o(rx_err)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    int n_rxv = 0, n_rxe = 0, n_txd = 0, n_txe = 0, n_oe_bad = 0;
    int run = 0, ovl = 0, inh_len = 0, inh_ovl = 0;
    int rxe_cyc = 0, last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and inhibit-window measurement, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid) n_rxv++;
        if (rx_err) begin n_rxe++; rxe_cyc = cyc; end
        if (tx_done) n_txd++;
        if (tx_err) n_txe++;
        if ((ps2_clk_oe || ps2_data_oe) && !tx_busy) n_oe_bad++;
        if (ps2_clk_oe) begin
            run++;
            if (ps2_data_oe) ovl++;
        end else if (run != 0) begin
            inh_len = run; inh_ovl = ovl; run = 0; ovl = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    function automatic logic [10:0] host_frame(input logic [7:0] b);
        return {1'b1, odd_par(b), b, 1'b0};
    endfunction

    // Device -> host frame, bits LSB first; optionally raise tx_req in the
    // cycle the controller sees the start-bit fall.
    task automatic dev_frame(input logic [7:0] d, input logic par, input logic stp,
                             input int nbits, input bit req_at_start);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_data = f[i];
            step(100);
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            if (i == 0 && req_at_start) begin
                step(6);
                tx_req = 1'b1;
                step(94);
                chk("busy_during_rx", tx_busy, 0);
            end else begin
                step(100);
            end
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        step(100);
    endtask

    // Host -> device frame: wait for release after inhibit, clock 10 bits,
    // then clock the ack bit.
    task automatic dev_receive(output logic [10:0] got, input bit ack, output bit ok);
        ok  = 1'b0;
        got = 'x;
        for (int i = 0; i < 3000; i++) begin
            if (tx_busy && !ps2_clk_oe && ps2_data_oe) begin ok = 1'b1; break; end
            step(1);
        end
        if (ok) begin
            step(50);
            got[0] = ps2_data_pad;
            for (int k = 1; k <= 10; k++) begin
                dev_clk = 1'b0;
                step(100);
                dev_clk = 1'b1;
                got[k] = ps2_data_pad;
                step(100);
            end
            dev_data = ack ? 1'b0 : 1'b1;
            step(50);
            dev_clk = 1'b0;
            step(100);
            dev_clk = 1'b1;
            step(50);
            dev_data = 1'b1;
            step(20);
        end
    endtask

    task automatic wait_busy(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (tx_busy) begin seen = 1'b1; break; end
            step(1);
        end
        chk(tag, seen, 1);
    endtask

    // One host transmission with ack choice, checked against the frame rule.
    task automatic do_tx(input logic [7:0] b, input bit ack, input string tag);
        logic [10:0] got;
        bit ok;
        int d0, e0;
        d0 = n_txd; e0 = n_txe;
        tx_data = b;
        tx_req  = 1'b1;
        wait_busy({tag, "_accept"});
        tx_req  = 1'b0;
        tx_data = ~b;
        dev_receive(got, ack, ok);
        step(20);
        chk({tag, "_release"}, ok, 1);
        chk({tag, "_frame"}, got, host_frame(b));
        chk({tag, "_inh_len"}, inh_len, 50);
        chk({tag, "_start_overlap"}, inh_ovl, 1);
        chk({tag, "_done"}, n_txd - d0, ack ? 1 : 0);
        chk({tag, "_err"}, n_txe - e0, ack ? 0 : 1);
        chk({tag, "_idle"}, {tx_busy, ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    // One device frame with a model-derived verdict.
    task automatic do_rx(input logic [7:0] d, input logic par, input logic stp, input string tag);
        int v0, e0;
        logic [7:0] prev;
        bit good;
        v0 = n_rxv; e0 = n_rxe; prev = rx_data;
        good = (par == odd_par(d)) && stp;
        dev_frame(d, par, stp, 11, 0);
        step(50);
        chk({tag, "_valid"}, n_rxv - v0, good ? 1 : 0);
        chk({tag, "_err"}, n_rxe - e0, good ? 0 : 1);
        chk({tag, "_data"}, rx_data, good ? d : prev);
    endtask

    initial begin
        logic [7:0] b1, b2;
        logic [10:0] got;
        bit ok;
        int e0, v0, dly;

        rst_n = 1'b0; tx_req = 1'b0; tx_data = 8'h00;
        dev_clk = 1'b1; dev_data = 1'b1;
        step(5);
        chk("reset_outputs", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err, rx_valid, rx_err}, 0);
        chk("reset_rx_data", rx_data, 8'h00);
        rst_n = 1'b1;
        step(20);

        // good frame, then bad parity keeps old byte
        do_rx(8'h1C, 1'b0, 1'b1, "rx_1c");
        do_rx(8'h1C, 1'b1, 1'b1, "rx_1c_badpar");

        // device stalls after 4 bits
        e0 = n_rxe; v0 = n_rxv;
        dev_frame(8'hA5, 1'b0, 1'b1, 4, 0);
        step(2100);
        dly = rxe_cyc - last_fall_cyc;
        chk("rx_timeout_err", n_rxe - e0, 1);
        chk("rx_timeout_valid", n_rxv - v0, 0);
        chk("rx_timeout_delay", (dly >= 2000 && dly <= 2012), 1);
        do_rx(8'hF0, odd_par(8'hF0), 1'b1, "rx_f0_after_to");

        // random device frames, occasionally corrupted
        for (int i = 0; i < 5; i++) begin
            b1 = 8'($urandom);
            do_rx(b1, odd_par(b1) ^ ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) != 0), "rx_rand");
        end

        do_tx(8'hFF, 1'b1, "tx_ff");
        do_tx(8'hED, 1'b0, "tx_ed_noack");
        for (int i = 0; i < 2; i++) begin
            do_tx(8'($urandom), 1'($urandom_range(0, 1)), "tx_rand");
        end

        // collision: start-bit fall and tx_req in the same cycle
        b1 = 8'($urandom); b2 = 8'($urandom);
        v0 = n_rxv;
        tx_data = b2;
        dev_frame(b1, odd_par(b1), 1'b1, 11, 1);
        chk("coll_rx_valid", n_rxv - v0, 1);
        chk("coll_rx_data", rx_data, b1);
        wait_busy("coll_tx_accept");
        tx_req = 1'b0;
        dev_receive(got, 1'b1, ok);
        step(20);
        chk("coll_tx_release", ok, 1);
        chk("coll_tx_frame", got, host_frame(b2));
        chk("coll_tx_busy", tx_busy, 0);

        // reset in the middle of inhibit
        tx_data = 8'($urandom);
        tx_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ps2_clk_oe) begin ok = 1'b1; break; end
            step(1);
        end
        chk("rst_inh_entered", ok, 1);
        step(10);
        rst_n = 1'b0;
        step(1);
        chk("rst_inh_release", {ps2_clk_oe, ps2_data_oe, tx_busy}, 0);
        chk("rst_inh_rx_data", rx_data, 8'h00);
        tx_req = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(20);
        b1 = 8'($urandom);
        do_rx(b1, odd_par(b1), 1'b1, "rx_after_rst");

        chk("oe_outside_tx", n_oe_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard stop if something stalls beyond every per-wait bound
    initial begin
        #5000000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "global timeout");
    end

endmodule
